key_autorepeat: RTL and testbench
=================================

Name: key_autorepeat

Overview:
- Front-end key conditioner feeding the clock/counter blocks' increment inputs, in place of a plain press detector.
- Synchronises a raw active-low push-button, debounces both press and release, and emits a one-cycle pulse on each press.
- While the key is held, emits further pulses: first after REPEAT_DELAY, then every REPEAT_PERIOD. Holding "incr" therefore sweeps minutes/hours quickly.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a press or release (10 ms at 50 MHz); ≥2.
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat pulse (0.5 s); ≥2.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (0.1 s); ≥2.
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = one pulse per press only.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_key  input  1  raw button, active-low (0 = pressed), asynchronous to clk.
- out_key  output  1  one-cycle pulse on accepted press and on each repeat.
- pressed  output  1  debounced key level, 1 = held.
- repeating  output  1  1 while in REPEAT state.

Behaviour:
- Reset: one clock, synchronous and active-high; ports named clk and rst. Reset is evaluated before all other logic.
- Reset values: both sync flops = 1 (released), state = IDLE, cnt = 0, out_key = 0, pressed = 0, repeating = 0.
- Synchroniser: in_key passes through 2 flops. s = ~sync2 (1 = pressed). The FSM sees only s.
- Counter: single shared cnt, width $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)). It is cleared on every state change and never wraps past its terminal value.
- IDLE:
  - s=1 -> DEB_PRESS, cnt=0.
- DEB_PRESS:
  - s=0 -> IDLE (bounce rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> HOLD, pressed<=1, out_key<=1 for one cycle.
  - Otherwise cnt++.
- HOLD:
  - s=0 -> DEB_RELEASE, cnt=0.
  - REPEAT_EN=1 and cnt==REPEAT_DELAY-1 -> REPEAT, out_key pulse, repeating<=1.
  - Otherwise cnt++. With REPEAT_EN=0, cnt saturates and never pulses.
- REPEAT:
  - s=0 -> DEB_RELEASE, repeating<=0.
  - cnt==REPEAT_PERIOD-1 -> out_key pulse, cnt=0.
  - Otherwise cnt++.
- DEB_RELEASE (pressed stays 1, no pulses):
  - s=1 -> HOLD, cnt=0. A release bounce restarts the repeat delay.
  - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, pressed<=0.
  - Otherwise cnt++.
- Latency: edge E1 = first rising edge sampling in_key=0, with in_key held low after it.
  - out_key is high for exactly the cycle after edge E(D+3), where D = DEBOUNCE_CYCLES.
  - Repeat pulses follow at E(D+3+REPEAT_DELAY), then every REPEAT_PERIOD edges.
- out_key is registered and never high for two consecutive cycles. That requires REPEAT_PERIOD≥2.
- pressed falls on edge E(D+3) after the release, counted the same way from the first edge sampling in_key=1.
- Reset mid-operation (any state): all outputs 0 on the next cycle and no pulse is emitted. A key still held after reset is re-debounced from IDLE as a new press.

Test Plan (D=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1):
- Reset: rst=1 for 2 cycles with in_key=0 -> out_key, pressed, repeating all 0. After release of rst, first pulse at E7 counted from the first post-reset edge.
- Clean press: in_key low for 8 cycles then high -> exactly one out_key pulse after E7; pressed=1 from E7; pressed falls at E7 after the release; no repeat pulse.
- Bounce: in_key low 3 cycles, high 1, low 2, high -> no out_key, pressed stays 0, state returns to IDLE.
- Long hold for 30 cycles -> pulses after E7, E17, E20, E23, E26, E29, E32 (the last is emitted while the release is still crossing the synchroniser); repeating=1 from E17 until the release; no pulses after release.
- Release bounce during REPEAT: 1-cycle high glitch -> DEB_RELEASE then back to HOLD; next pulse is 10 cycles after the return (delay restarted), not 3.
- REPEAT_EN=0 with a 40-cycle hold -> a single pulse after E7; repeating never asserts.

Source files
------------

// File: rtl/key_autorepeat.sv
// key_autorepeat: synchronises and debounces an active-low push-button,
// emits a one-cycle pulse per accepted press and, while the key is held,
// further pulses after REPEAT_DELAY and then every REPEAT_PERIOD cycles.
module key_autorepeat #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_key,
  output logic out_key,
  output logic pressed,
  output logic repeating
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW     = ($clog2(MAX_C) < 1) ? 1 : $clog2(MAX_C);

  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HOLD,
    REPEAT,
    DEB_RELEASE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          sync2;
  logic          s;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= in_key;
      sync2 <= sync1;
    end
  end

  // Active-high view of the synchronised key.
  always_comb begin
    s = ~sync2;
  end

  // Debounce / repeat FSM with a single shared counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_key   <= 1'b0;
      pressed   <= 1'b0;
      repeating <= 1'b0;
    end else begin
      out_key <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end

        DEB_PRESS: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state   <= HOLD;
            cnt     <= '0;
            pressed <= 1'b1;
            out_key <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (!s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end else if ((REPEAT_EN != 0) && (cnt == DELAY_LAST)) begin
            state     <= REPEAT;
            cnt       <= '0;
            out_key   <= 1'b1;
            repeating <= 1'b1;
          end else if (cnt != DELAY_LAST) begin
            // Without auto-repeat the counter parks at its terminal value.
            cnt <= cnt + 1'b1;
          end
        end

        REPEAT: begin
          if (!s) begin
            state     <= DEB_RELEASE;
            cnt       <= '0;
            repeating <= 1'b0;
          end else if (cnt == PERIOD_LAST) begin
            cnt     <= '0;
            out_key <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DEB_RELEASE: begin
          if (s) begin
            // A release bounce returns to HOLD and restarts the repeat delay.
            state <= HOLD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          pressed   <= 1'b0;
          repeating <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_autorepeat.sv
// Scoreboard bench for key_autorepeat: one instance with auto-repeat and one
// without, driven by directed and random key patterns. A timeline model of the
// key predicts pulses and levels; a monitor compares them on the falling edge.
module tb_key_autorepeat;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_key;
  logic out0, pr0, rp0;
  logic out1, pr1, rp1;

  always #5 clk = ~clk;

  key_autorepeat #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_EN(1)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .in_key(in_key),
    .out_key(out0),
    .pressed(pr0),
    .repeating(rp0)
  );

  key_autorepeat #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_EN(0)
  ) u_dut_norep (
    .clk(clk),
    .rst(rst),
    .in_key(in_key),
    .out_key(out1),
    .pressed(pr1),
    .repeating(rp1)
  );

  // Key timeline: 2-edge input delay, run lengths of the delayed key,
  // and the edge from which the current repeat delay is measured.
  typedef struct {
    bit d1;
    bit d2;
    bit pr;
    int streak;
    int rel;
    int since;
  } model_t;

  typedef struct {
    int tag;
    bit pr;
    bit rp;
  } lvl_t;

  model_t m0, m1;
  int     pq0[$];
  int     pq1[$];
  lvl_t   lq0[$];
  lvl_t   lq1[$];
  int     checks = 0;
  int     errors = 0;
  int     edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic model_t mstep(input model_t m, input bit k, input bit r,
                                   input int n, input bit en,
                                   output bit pulse, output bit rep);
    model_t x;
    bit     s;
    x     = m;
    pulse = 1'b0;
    rep   = 1'b0;
    if (r) begin
      x.d1 = 1'b1; x.d2 = 1'b1; x.pr = 1'b0;
      x.streak = 0; x.rel = 0; x.since = 0;
      return x;
    end
    s    = !x.d2;
    x.d2 = x.d1;
    x.d1 = k;
    if (!x.pr) begin
      x.rel = 0;
      if (s) begin
        x.streak++;
        if (x.streak == D + 1) begin
          x.pr = 1'b1; x.since = n; x.streak = 0; pulse = 1'b1;
        end
      end else begin
        x.streak = 0;
      end
    end else begin
      if (!s) begin
        x.rel++;
        if (x.rel == D + 1) begin
          x.pr = 1'b0; x.rel = 0; x.streak = 0;
        end
      end else if (x.rel > 0) begin
        x.since = n;
        x.rel   = 0;
      end else if (en && (n - x.since) >= RD && ((n - x.since - RD) % RP) == 0) begin
        pulse = 1'b1;
      end
    end
    rep = x.pr && (x.rel == 0) && en && ((n - x.since) >= RD);
    return x;
  endfunction

  task automatic drive(input bit k, input bit r);
    bit   p;
    bit   rep;
    int   n;
    lvl_t e;
    rst    = r;
    in_key = k;
    n      = edge_n + 1;
    m0 = mstep(m0, k, r, n, 1'b1, p, rep);
    if (p) pq0.push_back(n);
    e.tag = n; e.pr = m0.pr; e.rp = rep;
    lq0.push_back(e);
    m1 = mstep(m1, k, r, n, 1'b0, p, rep);
    if (p) pq1.push_back(n);
    e.tag = n; e.pr = m1.pr; e.rp = rep;
    lq1.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input bit k, input int cycles);
    for (int i = 0; i < cycles; i++) drive(k, 1'b0);
  endtask

  task automatic check_inst(input int i, input logic ok, input logic pr, input logic rp);
    lvl_t e;
    bit   have;
    bit   expp;
    have = 1'b0;
    expp = 1'b0;
    if (i == 0) begin
      if (lq0.size() > 0) begin e = lq0.pop_front(); have = 1'b1; end
      while (pq0.size() > 0 && pq0[0] < edge_n) begin
        checks++; errors++;
        $display("FAIL dut%0d missed_pulse: expected at edge %0d, now edge %0d", i, pq0[0], edge_n);
        void'(pq0.pop_front());
      end
      if (pq0.size() > 0 && pq0[0] == edge_n) begin expp = 1'b1; void'(pq0.pop_front()); end
    end else begin
      if (lq1.size() > 0) begin e = lq1.pop_front(); have = 1'b1; end
      while (pq1.size() > 0 && pq1[0] < edge_n) begin
        checks++; errors++;
        $display("FAIL dut%0d missed_pulse: expected at edge %0d, now edge %0d", i, pq1[0], edge_n);
        void'(pq1.pop_front());
      end
      if (pq1.size() > 0 && pq1[0] == edge_n) begin expp = 1'b1; void'(pq1.pop_front()); end
    end

    checks++;
    if (ok !== expp) begin
      errors++;
      $display("FAIL dut%0d out_key edge %0d: got %b want %b", i, edge_n, ok, expp);
    end

    checks++;
    if (!have || e.tag != edge_n) begin
      errors++;
      $display("FAIL dut%0d level_queue edge %0d: no expectation for this edge", i, edge_n);
    end else begin
      if (pr !== e.pr) begin
        errors++;
        $display("FAIL dut%0d pressed edge %0d: got %b want %b", i, edge_n, pr, e.pr);
      end
      checks++;
      if (rp !== e.rp) begin
        errors++;
        $display("FAIL dut%0d repeating edge %0d: got %b want %b", i, edge_n, rp, e.rp);
      end
    end
  endtask

  // Monitor: one comparison pass per clock, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check_inst(0, out0, pr0, rp0);
      check_inst(1, out1, pr1, rp1);
    end
  end

  // Stimulus: test-plan scenarios followed by random press/bounce patterns.
  initial begin
    bit level;
    int r;
    rst    = 1'b1;
    in_key = 1'b0;

    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    hold(1'b0, 12);
    hold(1'b1, 14);

    hold(1'b0, 8);
    hold(1'b1, 14);

    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 2);
    hold(1'b1, 14);

    hold(1'b0, 30);
    hold(1'b1, 14);

    hold(1'b0, 24);
    hold(1'b1, 1);
    hold(1'b0, 20);
    hold(1'b1, 14);

    hold(1'b0, 40);
    hold(1'b1, 14);

    hold(1'b0, 20);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    hold(1'b0, 15);
    hold(1'b1, 14);

    level = 1'b0;
    repeat (250) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        drive(level, 1'b1);
      end else begin
        hold(level, $urandom_range(1, (r < 50) ? 6 : 30));
      end
      level = ~level;
    end
    hold(1'b1, 14);

    @(negedge clk);
    #1;
    checks++;
    if (pq0.size() != 0 || pq1.size() != 0) begin
      errors++;
      $display("FAIL pulse_queue_drain: got %0d/%0d pending want 0/0", pq0.size(), pq1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
